// File: rtl/wb_hyper_arb.sv
// Two-master Wishbone arbiter in front of a single HyperRAM slave.
// Round-robin on ties, the grant is held for the owner's whole cycle, and a
// watchdog aborts an owner whose slave stops acking.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nobody owns the slave; arbitrate on requests
// OWN   | owner's cycle routed to the slave, watchdog running
// ABORT | owner timed out; slave strobe off until owner drops cyc
module wb_hyper_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [2:0]  m0_cti_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [2:0]  m1_cti_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic [2:0]  s_cti_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic        busy_o,
  output logic [7:0]  timeout_cnt_o
);

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  // Last watchdog value before the abort fires.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [7:0]  wd_q, wd_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        err_q, err_d;

  logic        req0, req1;
  logic        own_cyc, own_stb;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_q ? m1_stb_i : m0_stb_i;

  // State register plus owner, watchdog, abort counter and error pulse.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= 8'd0;
      tcnt_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state: arbitration, cycle hold, watchdog and abort decisions.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wd_d    = wd_q;
    tcnt_d  = tcnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = OWN;
          owner_d = (req0 && req1) ? ~last_q : req1;
          wd_d    = 8'd0;
        end
      end
      OWN: begin
        // A dropped cyc wins over everything; an ack on that same cycle is
        // still delivered by the output mux.
        if (!own_cyc) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (s_ack_i) begin
          wd_d = 8'd0;
        end else if (own_stb) begin
          if (wd_q == TO_LAST) begin
            state_d = ABORT;
            err_d   = 1'b1;
            if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          end else begin
            wd_d = wd_q + 8'd1;
          end
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: slave-side mux of the owner, ack/err steering, status.
  always_comb begin
    s_adr_o       = owner_q ? m1_adr_i : m0_adr_i;
    s_dat_o       = owner_q ? m1_dat_i : m0_dat_i;
    s_sel_o       = owner_q ? m1_sel_i : m0_sel_i;
    s_cti_o       = owner_q ? m1_cti_i : m0_cti_i;
    s_we_o        = owner_q ? m1_we_i  : m0_we_i;
    s_cyc_o       = (state_q == OWN) & own_cyc;
    s_stb_o       = (state_q == OWN) & own_stb;
    m0_dat_o      = s_dat_i;
    m1_dat_o      = s_dat_i;
    m0_ack_o      = (state_q == OWN) & ~owner_q & s_ack_i;
    m1_ack_o      = (state_q == OWN) &  owner_q & s_ack_i;
    m0_err_o      = err_q & ~owner_q;
    m1_err_o      = err_q &  owner_q;
    busy_o        = (state_q != IDLE);
    timeout_cnt_o = tcnt_q;
  end

endmodule

// File: tb/tb_wb_hyper_arb.sv
// Directed bench for wb_hyper_arb built with TIMEOUT=8.
module tb_wb_hyper_arb;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
  logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
  logic [2:0]  m0_cti_i = '0, m1_cti_i = '0;
  logic        m0_we_i = 0, m0_cyc_i = 0, m0_stb_i = 0;
  logic        m1_we_i = 0, m1_cyc_i = 0, m1_stb_i = 0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i = '0;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i = 0, busy_o;
  logic [7:0]  timeout_cnt_o;

  int checks = 0;
  int errors = 0;

  wb_hyper_arb #(.TIMEOUT(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_cti_i(m0_cti_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i),
    .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_cti_i(m1_cti_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i),
    .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cti_o(s_cti_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .busy_o(busy_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Advance one rising edge, then settle 1ns before driving/sampling.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic test_reset();
    wb_rst_ni = 1'b0;
    tick(); tick();
    checks++;
    if ({s_cyc_o, s_stb_o, busy_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 0000000",
        {s_cyc_o, s_stb_o, busy_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
    end
    checks++;
    if (timeout_cnt_o !== 8'd0) begin
      errors++; $display("FAIL reset_tcnt got %0d want 0", timeout_cnt_o);
    end
    wb_rst_ni = 1'b1;
  endtask

  task automatic test_tie();
    m0_adr_i = 32'h0000_1000; m0_sel_i = 4'hF; m0_we_i = 1'b0;
    m1_adr_i = 32'h0000_2000; m1_sel_i = 4'h3; m1_we_i = 1'b1; m1_dat_i = 32'hCAFE_0001;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    checks++;
    if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL tie_pre_grant s_cyc got %b want 0", s_cyc_o); end
    tick();
    checks++;
    if ({s_cyc_o, s_stb_o, busy_o} !== 3'b111 || s_adr_o !== 32'h0000_1000) begin
      errors++; $display("FAIL tie_m0_grant cyc/stb/busy=%b adr=%h want 111 00001000",
        {s_cyc_o, s_stb_o, busy_o}, s_adr_o);
    end
    s_dat_i = 32'h1234_5678; s_ack_i = 1;
    #1;
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10 || m0_dat_o !== 32'h1234_5678 || m1_dat_o !== 32'h1234_5678) begin
      errors++; $display("FAIL tie_m0_ack acks=%b d0=%h d1=%h want 10 12345678",
        {m0_ack_o, m1_ack_o}, m0_dat_o, m1_dat_o);
    end
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    checks++;
    if ({s_cyc_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL tie_gap cyc/busy got %b want 00", {s_cyc_o, busy_o});
    end
    tick();
    checks++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_2000 || s_we_o !== 1'b1 ||
        s_sel_o !== 4'h3 || s_dat_o !== 32'hCAFE_0001) begin
      errors++; $display("FAIL tie_m1_grant cyc=%b adr=%h we=%b sel=%h dat=%h want 1 00002000 1 3 cafe0001",
        s_cyc_o, s_adr_o, s_we_o, s_sel_o, s_dat_o);
    end
    s_ack_i = 1;
    tick();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    tick(); tick();
  endtask

  task automatic test_burst();
    int bad0 = 0;
    int acks1 = 0;
    m1_adr_i = 32'h0000_3000; m1_cti_i = 3'b010; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    m0_adr_i = 32'h0000_4000; m0_cyc_i = 1; m0_stb_i = 1;
    for (int b = 0; b < 4; b++) begin
      m1_adr_i = 32'h0000_3000 + 32'(b * 4);
      m1_cti_i = (b == 3) ? 3'b111 : 3'b010;
      s_ack_i = 1;
      #1;
      if (m0_ack_o) bad0++;
      if (m1_ack_o && s_adr_o == m1_adr_i && s_cti_o == m1_cti_i) acks1++;
      tick();
    end
    s_ack_i = 0;
    checks++;
    if (acks1 !== 4) begin errors++; $display("FAIL burst_m1_acks got %0d want 4", acks1); end
    checks++;
    if (bad0 !== 0) begin errors++; $display("FAIL burst_m0_ack got %0d want 0", bad0); end
    m1_cyc_i = 0; m1_stb_i = 0; m1_cti_i = 3'b000;
    tick();
    tick();
    checks++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_4000) begin
      errors++; $display("FAIL burst_m0_after cyc=%b adr=%h want 1 00004000", s_cyc_o, s_adr_o);
    end
    s_ack_i = 1;
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int stb_lo = 0;
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (!s_stb_o || m0_err_o) stb_lo++;
      tick();
    end
    checks++;
    if (stb_lo !== 0) begin errors++; $display("FAIL to_wait stb/err bad cycles got %0d want 0", stb_lo); end
    checks++;
    if ({m0_err_o, m1_err_o, busy_o, s_stb_o, s_cyc_o} !== 5'b10100 || timeout_cnt_o !== 8'd1) begin
      errors++; $display("FAIL to_abort err0/err1/busy/stb/cyc=%b tcnt=%0d want 10100 1",
        {m0_err_o, m1_err_o, busy_o, s_stb_o, s_cyc_o}, timeout_cnt_o);
    end
    pulses++;
    s_ack_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m0_err_o) pulses++;
      if (s_stb_o || m0_ack_o) stb_lo++;
    end
    s_ack_i = 0;
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL to_err_pulses got %0d want 1", pulses); end
    checks++;
    if (stb_lo !== 0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL to_hold stb/late-ack cycles=%0d busy=%b want 0 1", stb_lo, busy_o);
    end
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL to_release busy got %b want 0", busy_o); end
    tick();
  endtask

  task automatic test_ack_on_last();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    s_ack_i = 1;
    #1;
    checks++;
    if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL last_ack ack got %b want 1", m0_ack_o); end
    tick();
    s_ack_i = 0;
    checks++;
    if ({m0_err_o, busy_o, s_stb_o} !== 3'b011 || timeout_cnt_o !== 8'd1) begin
      errors++; $display("FAIL last_noabort err/busy/stb=%b tcnt=%0d want 011 1",
        {m0_err_o, busy_o, s_stb_o}, timeout_cnt_o);
    end
    m0_cyc_i = 0; m0_stb_i = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    m0_adr_i = 32'h0000_5000; m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    checks++;
    if (s_cyc_o !== 1'b1) begin errors++; $display("FAIL rst_pre cyc got %b want 1", s_cyc_o); end
    m1_cyc_i = 1; m1_stb_i = 1;
    #2 wb_rst_ni = 1'b0;
    s_ack_i = 1;
    #1;
    checks++;
    if ({s_cyc_o, s_stb_o, busy_o, m0_ack_o, m0_err_o} !== 5'b0) begin
      errors++; $display("FAIL rst_async cyc/stb/busy/ack/err=%b want 00000",
        {s_cyc_o, s_stb_o, busy_o, m0_ack_o, m0_err_o});
    end
    s_ack_i = 0;
    #2 wb_rst_ni = 1'b1;
    tick();
    checks++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_5000 || timeout_cnt_o !== 8'd0) begin
      errors++; $display("FAIL rst_regrant cyc=%b adr=%h tcnt=%0d want 1 00005000 0",
        s_cyc_o, s_adr_o, timeout_cnt_o);
    end
    s_ack_i = 1;
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    tick();
    s_ack_i = 1;
    tick();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick(); tick();
  endtask

  task automatic test_saturate();
    int missed = 0;
    for (int i = 0; i < 300; i++) begin
      int seen = 0;
      m0_cyc_i = 1; m0_stb_i = 1;
      for (int c = 0; c < 20 && seen == 0; c++) begin
        tick();
        if (m0_err_o) seen = 1;
      end
      if (seen == 0) missed++;
      m0_cyc_i = 0; m0_stb_i = 0;
      tick();
      if (i == 253) begin
        checks++;
        if (timeout_cnt_o !== 8'd254) begin
          errors++; $display("FAIL sat_254 tcnt got %0d want 254", timeout_cnt_o);
        end
      end
    end
    checks++;
    if (missed !== 0) begin errors++; $display("FAIL sat_missed_aborts got %0d want 0", missed); end
    checks++;
    if (timeout_cnt_o !== 8'd255) begin
      errors++; $display("FAIL sat_255 tcnt got %0d want 255", timeout_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_burst();
    test_timeout();
    test_ack_on_last();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
